// File: rtl/disp_pkg.sv
// Shared types, constants and helpers for the multiplexed 7-segment scan controller.
package disp_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  localparam int         NUM_DIGITS = 8;
  localparam logic [7:0] AN_OFF     = 8'hFF;

  // Index of the most significant non-zero nibble; 0 when the whole value is zero.
  function automatic logic [2:0] msd_of(input logic [31:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int k = 1; k < NUM_DIGITS; k++) begin
      if (v[4*k +: 4] != 4'h0) idx = 3'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/scan_timer.sv
// Per-slot cycle counter: strobes the last blank cycle and the last cycle of each digit slot.
module scan_timer #(
  parameter int unsigned SCAN_DIV     = 200000,
  parameter int unsigned BLANK_CYCLES = 2000
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic blank_end_o,
  output logic slot_end_o
);

  localparam logic [23:0] LAST_CNT   = 24'(SCAN_DIV - 1);
  localparam logic [23:0] BLANK_LAST = 24'(BLANK_CYCLES - 1);

  logic [23:0] cnt_q, cnt_d;

  // NOTE: every signal written here gets a value on every path, so no latch is inferred.
  always_comb begin
    slot_end_o  = (cnt_q == LAST_CNT);
    blank_end_o = (cnt_q == BLANK_LAST);
    cnt_d       = slot_end_o ? 24'd0 : cnt_q + 24'd1;
  end

  // NOTE: non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= 24'd0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Scan scheduler for the 8-digit display: slot timing, anti-ghost blanking,
// digit/leading-zero masking and frame-synchronous double buffering of the shown value.
module display_scan_ctrl
  import disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 200000,
  parameter int unsigned BLANK_CYCLES = 2000
) (
  input  logic        CLK100MHZ,
  input  logic        reset,
  input  logic [31:0] value,
  input  logic        load,
  output logic        load_ack,
  input  logic [7:0]  digit_en,
  input  logic        lz_suppress,
  output logic [3:0]  hex_out,
  output logic [7:0]  AN,
  output logic        frame_done
);

  localparam logic [2:0] LAST_DIGIT = 3'(NUM_DIGITS - 1);

  logic        blank_end;
  logic        slot_end;

  scan_state_t state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [31:0] active_q, active_d;
  logic [31:0] pending_q, pending_d;
  logic        pend_valid_q, pend_valid_d;
  logic [7:0]  an_q, an_d;
  logic [3:0]  hex_q, hex_d;
  logic        load_ack_q;
  logic        frame_done_q;
  logic        frame_end;
  logic        shown;

  scan_timer #(
    .SCAN_DIV    (SCAN_DIV),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_scan_timer (
    .clk_i      (CLK100MHZ),
    .rst_i      (reset),
    .blank_end_o(blank_end),
    .slot_end_o (slot_end)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    active_d     = active_q;
    pending_d    = pending_q;
    pend_valid_d = pend_valid_q;
    frame_end    = 1'b0;

    unique case (state_q)
      BLANK: if (blank_end) state_d = DRIVE;
      DRIVE: if (slot_end) begin
        state_d   = BLANK;
        idx_d     = idx_q + 3'd1;
        frame_end = (idx_q == LAST_DIGIT);
      end
    endcase

    // The boundary transfer sees the old pending word even if a load lands this cycle.
    if (frame_end && pend_valid_q) begin
      active_d     = pending_q;
      pend_valid_d = 1'b0;
    end
    if (load) begin
      pending_d    = value;
      pend_valid_d = 1'b1;
    end

    // Outputs are computed from next-state values so the registers line up with the slot.
    shown = digit_en[idx_d] && !(lz_suppress && (idx_d > msd_of(active_d)));
    hex_d = active_d[{idx_d, 2'b00} +: 4];
    an_d  = (state_d == DRIVE && shown) ? ~(8'h01 << idx_d) : AN_OFF;
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state_q      <= BLANK;
      idx_q        <= 3'd0;
      active_q     <= 32'd0;
      pending_q    <= 32'd0;
      pend_valid_q <= 1'b0;
      an_q         <= AN_OFF;
      hex_q        <= 4'h0;
      load_ack_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      pend_valid_q <= pend_valid_d;
      an_q         <= an_d;
      hex_q        <= hex_d;
      load_ack_q   <= load;
      frame_done_q <= frame_end;
    end
  end

  assign AN         = an_q;
  assign hex_out    = hex_q;
  assign load_ack   = load_ack_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl with an 8-cycle slot and 2-cycle blank.
module tb_display_scan_ctrl;

  localparam int SD = 8;
  localparam int BC = 2;
  localparam int FRAME = 8 * SD;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] value;
  logic        load;
  logic        load_ack;
  logic [7:0]  digit_en;
  logic        lz_suppress;
  logic [3:0]  hex_out;
  logic [7:0]  an;
  logic        frame_done;

  always #5 clk = ~clk;

  display_scan_ctrl #(
    .SCAN_DIV    (SD),
    .BLANK_CYCLES(BC)
  ) dut (
    .CLK100MHZ  (clk),
    .reset      (reset),
    .value      (value),
    .load       (load),
    .load_ack   (load_ack),
    .digit_en   (digit_en),
    .lz_suppress(lz_suppress),
    .hex_out    (hex_out),
    .AN         (an),
    .frame_done (frame_done)
  );

  typedef struct {
    logic [31:0] val;
    logic [7:0]  en;
    logic        lz;
    logic [7:0]  mask;  // digits expected to light up, worked out by hand
  } vec_t;

  vec_t vecs[8];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int ack_q[$];

  // Reference state: value shown this frame, pending word, and lit-digit masks.
  logic [31:0] exp_val    = 32'd0;
  logic [31:0] pend_val   = 32'd0;
  logic        pend_valid = 1'b0;
  logic [7:0]  exp_mask   = 8'h00;
  logic [7:0]  next_mask  = 8'h00;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, got, exp);
    end
  endtask

  // One clock: advance the reference model, then compare every output.
  task automatic step();
    logic        rst_s, ld_s, e_fd, e_ack;
    logic [31:0] v_s;
    logic [7:0]  e_an;
    logic [3:0]  e_hex;
    int          pos, dig;
    rst_s = reset;
    ld_s  = load;
    v_s   = value;
    @(posedge clk);
    #1;
    if (rst_s) begin
      cyc        = 0;
      exp_val    = 32'd0;
      pend_valid = 1'b0;
      exp_mask   = next_mask;
      ack_q.delete();
    end else begin
      cyc++;
      if (cyc % FRAME == 0) begin
        if (pend_valid) begin
          exp_val    = pend_val;
          pend_valid = 1'b0;
        end
        exp_mask = next_mask;
      end
      if (ld_s) begin
        pend_val   = v_s;
        pend_valid = 1'b1;
      end
    end
    pos   = cyc % SD;
    dig   = (cyc / SD) % 8;
    e_hex = exp_val[dig*4 +: 4];
    e_an  = (pos < BC || !exp_mask[dig]) ? 8'hFF : ~(8'h01 << dig);
    e_fd  = (cyc > 0) && (cyc % FRAME == 0);
    check("scan{AN,hex,frame_done}", {19'd0, an, hex_out, frame_done}, {19'd0, e_an, e_hex, e_fd});
    e_ack = (ack_q.size() > 0) && (ack_q[0] == cyc);
    if (e_ack) void'(ack_q.pop_front());
    check("load_ack", {31'd0, load_ack}, {31'd0, e_ack});
  endtask

  task automatic run_to(input int p);
    while (cyc % FRAME != p) step();
  endtask

  task automatic do_load(input logic [31:0] v);
    load  = 1'b1;
    value = v;
    ack_q.push_back(cyc + 1);
    step();
    load  = 1'b0;
  endtask

  initial begin
    vecs[0] = '{32'h89ABCDEF, 8'hFF, 1'b0, 8'hFF};
    vecs[1] = '{32'h00000A05, 8'hFF, 1'b1, 8'h07};
    vecs[2] = '{32'h00000000, 8'hFF, 1'b1, 8'h01};
    vecs[3] = '{32'h89ABCDEF, 8'h55, 1'b0, 8'h55};
    vecs[4] = '{32'h0000F000, 8'hFF, 1'b1, 8'h0F};
    vecs[5] = '{32'h00000000, 8'hFE, 1'b1, 8'h00};
    vecs[6] = '{32'h10000000, 8'hF0, 1'b1, 8'hF0};
    vecs[7] = '{32'h00000A05, 8'hFF, 1'b0, 8'hFF};

    reset       = 1'b1;
    load        = 1'b0;
    value       = 32'd0;
    digit_en    = 8'h00;
    lz_suppress = 1'b0;
    step();
    step();
    reset = 1'b0;

    // Each vector is loaded early in a frame, its masks change in the boundary
    // cycle, and the whole following frame is compared cycle by cycle.
    for (int i = 0; i < 8; i++) begin
      run_to(4);
      do_load(vecs[i].val);
      run_to(FRAME - 1);
      digit_en    = vecs[i].en;
      lz_suppress = vecs[i].lz;
      next_mask   = vecs[i].mask;
      step();
    end

    // Two loads in one frame: the current frame is untouched, the later one wins.
    run_to(10);
    do_load(32'h11111111);
    run_to(12);
    do_load(32'h22222222);
    next_mask = 8'hFF;
    run_to(FRAME - 1);
    step();

    // Held load recaptures and re-acks every cycle.
    run_to(30);
    load = 1'b1;
    for (int k = 3; k <= 5; k++) begin
      value = {8{4'(k)}};
      ack_q.push_back(cyc + 1);
      step();
    end
    load = 1'b0;
    run_to(FRAME - 1);
    step();

    // Load in the boundary cycle lands one frame later than the earlier load.
    run_to(20);
    do_load(32'hAAAAAAAA);
    run_to(FRAME - 1);
    do_load(32'hBBBBBBBB);
    run_to(FRAME - 1);
    step();

    // Reset during digit 4 DRIVE with a pending word and a load in flight.
    run_to(30);
    do_load(32'h0C0C0C0C);
    run_to(4 * SD + 4);
    reset = 1'b1;
    load  = 1'b1;
    value = 32'hDEADBEEF;
    step();
    reset = 1'b0;
    load  = 1'b0;
    run_to(FRAME - 1);
    step();
    run_to(FRAME - 1);
    step();

    check("ack_queue_drained", ack_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
